// File: rtl/ram_sdp_be_pkg.sv
// ram_pkg: shared types, read-during-write mode codes and byte-merge helper for ram_sdp_be.
package ram_pkg;
    typedef enum logic {ST_IDLE, ST_CLEAR} ram_clr_st_t;
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DW = 256;
    localparam int MAX_BE = MAX_DW / 8;
    function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_BE-1:0] be);
        logic [MAX_DW-1:0] r;
        for (int i = 0; i < MAX_BE; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/ram_sdp_be_if.sv
// ram_sdp_be_if: write/read/clear port bundle of the simple-dual-port RAM.
interface ram_sdp_be_if #(parameter int DATA_WIDE = 32, parameter int ADDR_WIDE = 9);
    logic                   clr_req;
    logic                   busy;
    logic                   wr_en;
    logic [ADDR_WIDE-1:0]   wr_addr;
    logic [DATA_WIDE/8-1:0] wr_be;
    logic [DATA_WIDE-1:0]   wr_data;
    logic                   re_en;
    logic [ADDR_WIDE-1:0]   rd_addr;
    logic [DATA_WIDE-1:0]   rd_data;
    logic                   rd_valid;
    modport master (output clr_req, wr_en, wr_addr, wr_be, wr_data, re_en, rd_addr,
                    input  busy, rd_data, rd_valid);
    modport slave  (input  clr_req, wr_en, wr_addr, wr_be, wr_data, re_en, rd_addr,
                    output busy, rd_data, rd_valid);
endinterface

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: RD_LAT-stage {valid, data} delay line; data stages only load on valid so the output holds.
module ram_rd_pipe #(parameter int DATA_WIDE = 32, parameter int RD_LAT = 1) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_WIDE-1:0] in_data,
    output logic                 out_valid,
    output logic [DATA_WIDE-1:0] out_data
);
    logic [RD_LAT-1:0]    v;
    logic [DATA_WIDE-1:0] d [RD_LAT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
        end else begin
            v[0] <= in_valid;
            d[0] <= in_valid ? in_data : d[0];
            for (int i = 1; i < RD_LAT; i++) begin
                v[i] <= v[i-1];
                d[i] <= v[i-1] ? d[i-1] : d[i];
            end
        end
    end
    assign out_valid = v[RD_LAT-1];
    assign out_data  = d[RD_LAT-1];
endmodule

// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple-dual-port RAM with byte enables, configurable read latency,
// selectable read-during-write policy and a clear engine that zeroes the array.
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int DATA_WIDE = 32,
    parameter int DEEP      = 512,
    parameter int ADDR_WIDE = $clog2(DEEP),
    parameter int RD_LAT    = 1,
    parameter int RDW_MODE  = RDW_READ_FIRST
) (
    input logic          clk,
    input logic          rst_n,
    ram_sdp_be_if.slave  bus
);
    localparam logic [ADDR_WIDE:0]   DEPTH = (ADDR_WIDE+1)'(DEEP);
    localparam logic [ADDR_WIDE-1:0] LAST  = ADDR_WIDE'(DEEP-1);

    if (DATA_WIDE % 8 != 0 || DATA_WIDE > MAX_DW || RD_LAT < 1 || RD_LAT > 3) begin : g_bad
        $fatal(1, "ram_sdp_be: illegal DATA_WIDE/RD_LAT");
    end

    ram_clr_st_t          state, state_nxt;
    logic [ADDR_WIDE-1:0] cnt;
    logic                 wr_ok, rd_in, hit;
    logic [DATA_WIDE-1:0] mem [DEEP];
    logic [DATA_WIDE-1:0] wr_word, rd_word, rd_word_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ST_CLEAR && cnt != LAST) ? cnt + 1'b1 : '0;
        end
    end

    always_comb state_nxt = state == ST_CLEAR ? (cnt == LAST ? ST_IDLE : ST_CLEAR)
                                              : (bus.clr_req ? ST_CLEAR : ST_IDLE);

    always_comb bus.busy = state == ST_CLEAR;

    always_comb begin
        wr_ok      = !bus.busy && bus.wr_en && {1'b0, bus.wr_addr} < DEPTH;
        rd_in      = {1'b0, bus.rd_addr} < DEPTH;
        wr_word    = DATA_WIDE'(be_merge(MAX_DW'(mem[bus.wr_addr]), MAX_DW'(bus.wr_data), MAX_BE'(bus.wr_be)));
        rd_word    = rd_in ? mem[bus.rd_addr] : '0;
        // Same-address bypass only in write-first mode; the merged word is exactly what gets stored.
        hit        = RDW_MODE == RDW_WRITE_FIRST && wr_ok && bus.wr_addr == bus.rd_addr;
        rd_word_in = hit ? wr_word : rd_word;
    end

    always_ff @(posedge clk) begin
        if (bus.busy) mem[cnt] <= '0;
        else if (wr_ok) mem[bus.wr_addr] <= wr_word;
    end

    ram_rd_pipe #(.DATA_WIDE(DATA_WIDE), .RD_LAT(RD_LAT)) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.re_en && !bus.busy),
        .in_data   (rd_word_in),
        .out_valid (bus.rd_valid),
        .out_data  (bus.rd_data)
    );
endmodule
